// File: rtl/uart_pkg.sv
// uart_pkg: shared UART defaults, count-width helper and read-mode constants
package uart_pkg;
    localparam int DATA_SIZE_DEF = 8;
    localparam bit FWFT_ON = 1'b1;
    localparam bit FWFT_OFF = 1'b0;
    function automatic int cw_f(input int n);
        return $clog2(n + 1);
    endfunction
endpackage

// File: rtl/uart_fifo_flags_if.sv
// uart_fifo_flags_if: host-side FIFO bus, master drives requests, slave returns data and flags
interface uart_fifo_flags_if import uart_pkg::*; #(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int SIZE_FIFO = 16
);
    localparam int CW = cw_f(SIZE_FIFO);
    logic s_tick, wr, rd, clr_err;
    logic [DATA_SIZE-1:0] w_data, r_data;
    logic r_valid, full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0] count;
    modport master (
        output s_tick, w_data, wr, rd, clr_err,
        input r_data, r_valid, count, full, empty, almost_full, almost_empty, overflow, underflow
    );
    modport slave (
        input s_tick, w_data, wr, rd, clr_err,
        output r_data, r_valid, count, full, empty, almost_full, almost_empty, overflow, underflow
    );
endinterface

// File: rtl/uart_fifo_flags_mem.sv
// uart_fifo_mem: register array with one sync write port and one async read port
module uart_fifo_mem #(
    parameter int DATA_SIZE = 8,
    parameter int DEPTH = 16,
    parameter int AW = 4
) (
    input logic clk,
    input logic we,
    input logic [AW-1:0] waddr,
    input logic [DATA_SIZE-1:0] wdata,
    input logic [AW-1:0] raddr,
    output logic [DATA_SIZE-1:0] rdata
);
    logic [DATA_SIZE-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/uart_fifo_flags.sv
// uart_fifo_flags: parametrised UART FIFO with fill count, thresholds, sticky errors and read mode
module uart_fifo_flags import uart_pkg::*; #(
    parameter int DATA_SIZE = DATA_SIZE_DEF,
    parameter int SIZE_FIFO = 16,
    parameter int AF_LEVEL = 12,
    parameter int AE_LEVEL = 2,
    parameter bit FWFT = FWFT_ON
) (
    input logic clk,
    input logic reset,
    uart_fifo_flags_if.slave bus
);
    localparam int CW = cw_f(SIZE_FIFO);
    localparam int AW = $clog2(SIZE_FIFO);
    if (AF_LEVEL < 1 || AF_LEVEL > SIZE_FIFO) begin : g_af_bad
        $error("uart_fifo_flags: AF_LEVEL out of range");
    end
    if (AE_LEVEL < 0 || AE_LEVEL > SIZE_FIFO - 1) begin : g_ae_bad
        $error("uart_fifo_flags: AE_LEVEL out of range");
    end
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [DATA_SIZE-1:0] head, rd_q;
    logic rv_q, do_rd, do_wr;
    uart_fifo_mem #(.DATA_SIZE(DATA_SIZE), .DEPTH(SIZE_FIFO), .AW(AW)) u_mem (
        .clk(clk),
        .we(do_wr),
        .waddr(wr_ptr),
        .wdata(bus.w_data),
        .raddr(rd_ptr),
        .rdata(head)
    );
    // a full FIFO still accepts a write when a pop frees a slot in the same cycle
    always_comb begin
        do_rd = bus.s_tick & bus.rd & ~bus.empty;
        do_wr = bus.s_tick & bus.wr & (~bus.full | do_rd);
        cnt_nxt = (do_wr & ~do_rd) ? cnt + CW'(1) : (do_rd & ~do_wr) ? cnt - CW'(1) : cnt;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt <= '0;
            bus.empty <= 1'b1;
            bus.full <= 1'b0;
            bus.almost_empty <= 1'b1;
            bus.almost_full <= 1'b0;
            bus.overflow <= 1'b0;
            bus.underflow <= 1'b0;
            rd_q <= '0;
            rv_q <= 1'b0;
        end else begin
            if (do_wr) wr_ptr <= (wr_ptr == AW'(SIZE_FIFO - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_rd) rd_ptr <= (rd_ptr == AW'(SIZE_FIFO - 1)) ? '0 : rd_ptr + AW'(1);
            if (do_rd) rd_q <= head;
            rv_q <= do_rd;
            cnt <= cnt_nxt;
            bus.empty <= cnt_nxt == '0;
            bus.full <= cnt_nxt == CW'(SIZE_FIFO);
            bus.almost_empty <= cnt_nxt <= CW'(AE_LEVEL);
            bus.almost_full <= cnt_nxt >= CW'(AF_LEVEL);
            bus.overflow <= (bus.overflow & ~bus.clr_err) | (bus.s_tick & bus.wr & ~do_wr);
            bus.underflow <= (bus.underflow & ~bus.clr_err) | (bus.s_tick & bus.rd & bus.empty);
        end
    end
    assign bus.count = cnt;
    assign bus.r_data = (FWFT == FWFT_ON) ? head : rd_q;
    assign bus.r_valid = (FWFT == FWFT_ON) ? ~bus.empty : rv_q;
endmodule

// File: tb/tb_uart_fifo_flags.sv
// tb_uart_fifo_flags: directed table and sequence checks on three FIFO configurations
module tb_uart_fifo_flags;
    import uart_pkg::*;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int errors = 0;
    always #5 clk = ~clk;
    uart_fifo_flags_if #(.DATA_SIZE(8), .SIZE_FIFO(16)) ia ();
    uart_fifo_flags_if #(.DATA_SIZE(8), .SIZE_FIFO(5)) ib ();
    uart_fifo_flags_if #(.DATA_SIZE(8), .SIZE_FIFO(16)) ic ();
    uart_fifo_flags #(.DATA_SIZE(8), .SIZE_FIFO(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(FWFT_ON))
        dut_a (.clk(clk), .reset(reset), .bus(ia));
    uart_fifo_flags #(.DATA_SIZE(8), .SIZE_FIFO(5), .AF_LEVEL(4), .AE_LEVEL(1), .FWFT(FWFT_ON))
        dut_b (.clk(clk), .reset(reset), .bus(ib));
    uart_fifo_flags #(.DATA_SIZE(8), .SIZE_FIFO(16), .AF_LEVEL(12), .AE_LEVEL(2), .FWFT(FWFT_OFF))
        dut_c (.clk(clk), .reset(reset), .bus(ic));
    typedef struct {
        logic st, wr, rd, clr;
        logic [7:0] wd;
        int cnt;
        logic e, f, ae, af, ov, un, cd;
        logic [7:0] d;
    } vec_t;
    vec_t tbl [14];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic step_a(input logic st, input logic w, input logic r, input logic c, input logic [7:0] d);
        ia.s_tick = st; ia.wr = w; ia.rd = r; ia.clr_err = c; ia.w_data = d;
        @(posedge clk);
        #1;
        ia.wr = 1'b0; ia.rd = 1'b0; ia.clr_err = 1'b0;
    endtask
    task automatic step_b(input logic w, input logic r, input logic [7:0] d);
        ib.s_tick = 1'b1; ib.wr = w; ib.rd = r; ib.clr_err = 1'b0; ib.w_data = d;
        @(posedge clk);
        #1;
        ib.wr = 1'b0; ib.rd = 1'b0;
    endtask
    task automatic step_c(input logic w, input logic r, input logic [7:0] d);
        ic.s_tick = 1'b1; ic.wr = w; ic.rd = r; ic.clr_err = 1'b0; ic.w_data = d;
        @(posedge clk);
        #1;
        ic.wr = 1'b0; ic.rd = 1'b0;
    endtask
    initial begin
        logic [7:0] exp_d;
        int n;
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[1]  = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h11, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h11};
        tbl[4]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        tbl[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
        tbl[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h44, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
        tbl[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 8'h55, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h33};
        tbl[10] = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h66, 3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h44};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 2, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h55};
        tbl[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'h66};
        tbl[13] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
        {ia.s_tick, ia.wr, ia.rd, ia.clr_err, ia.w_data} = '0;
        {ib.s_tick, ib.wr, ib.rd, ib.clr_err, ib.w_data} = '0;
        {ic.s_tick, ic.wr, ic.rd, ic.clr_err, ic.w_data} = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_count", ia.count, 0);
        chk("rst_empty", ia.empty, 1);
        chk("rst_full", ia.full, 0);
        chk("rst_ae", ia.almost_empty, 1);
        chk("rst_af", ia.almost_full, 0);
        chk("rst_ov", ia.overflow, 0);
        chk("rst_un", ia.underflow, 0);
        chk("rst_rvalid_a", ia.r_valid, 0);
        chk("rst_rvalid_c", ic.r_valid, 0);
        chk("rst_rdata_c", ic.r_data, 0);
        for (int i = 0; i < 14; i++) begin
            step_a(tbl[i].st, tbl[i].wr, tbl[i].rd, tbl[i].clr, tbl[i].wd);
            chk($sformatf("tbl%0d_count", i), ia.count, tbl[i].cnt);
            chk($sformatf("tbl%0d_empty", i), ia.empty, tbl[i].e);
            chk($sformatf("tbl%0d_full", i), ia.full, tbl[i].f);
            chk($sformatf("tbl%0d_ae", i), ia.almost_empty, tbl[i].ae);
            chk($sformatf("tbl%0d_af", i), ia.almost_full, tbl[i].af);
            chk($sformatf("tbl%0d_ov", i), ia.overflow, tbl[i].ov);
            chk($sformatf("tbl%0d_un", i), ia.underflow, tbl[i].un);
            chk($sformatf("tbl%0d_rvalid", i), ia.r_valid, !tbl[i].e);
            if (tbl[i].cd) chk($sformatf("tbl%0d_rdata", i), ia.r_data, tbl[i].d);
        end
        for (int i = 0; i < 16; i++) begin
            step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'(i));
            chk($sformatf("fill%0d_count", i), ia.count, i + 1);
            chk($sformatf("fill%0d_af", i), ia.almost_full, i + 1 >= 12);
            chk($sformatf("fill%0d_ae", i), ia.almost_empty, i + 1 <= 2);
            chk($sformatf("fill%0d_full", i), ia.full, i == 15);
        end
        chk("full_head", ia.r_data, 8'h00);
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'hEE);
        chk("ovf_flag", ia.overflow, 1);
        chk("ovf_count", ia.count, 16);
        chk("ovf_un", ia.underflow, 0);
        chk("ovf_head", ia.r_data, 8'h00);
        step_a(1'b1, 1'b0, 1'b0, 1'b1, 8'h00);
        chk("clr_ov", ia.overflow, 0);
        step_a(1'b1, 1'b1, 1'b1, 1'b0, 8'hA5);
        chk("fullrw_count", ia.count, 16);
        chk("fullrw_full", ia.full, 1);
        chk("fullrw_ov", ia.overflow, 0);
        for (int i = 0; i < 16; i++) begin
            exp_d = (i < 15) ? 8'(i + 1) : 8'hA5;
            chk($sformatf("drain%0d_data", i), ia.r_data, exp_d);
            step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
            chk($sformatf("drain%0d_count", i), ia.count, 15 - i);
            chk($sformatf("drain%0d_ae", i), ia.almost_empty, 15 - i <= 2);
            chk($sformatf("drain%0d_af", i), ia.almost_full, 15 - i >= 12);
        end
        chk("drain_empty", ia.empty, 1);
        chk("drain_ov", ia.overflow, 0);
        chk("drain_un", ia.underflow, 0);
        step_a(1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        chk("undf_flag", ia.underflow, 1);
        for (int i = 0; i < 7; i++) step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        chk("pre_rst_count", ia.count, 7);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("mid_rst_count", ia.count, 0);
        chk("mid_rst_empty", ia.empty, 1);
        chk("mid_rst_un", ia.underflow, 0);
        chk("mid_rst_ov", ia.overflow, 0);
        chk("mid_rst_ae", ia.almost_empty, 1);
        step_a(1'b1, 1'b1, 1'b0, 1'b0, 8'h77);
        chk("post_rst_head", ia.r_data, 8'h77);
        chk("post_rst_count", ia.count, 1);
        n = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 3; i++) step_b(1'b1, 1'b0, 8'(8'h80 + r * 3 + i));
            chk($sformatf("wrap%0d_count", r), ib.count, 3);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("wrap%0d_data%0d", r, i), ib.r_data, 8'(8'h80 + n));
                step_b(1'b0, 1'b1, 8'h00);
                n++;
            end
            chk($sformatf("wrap%0d_empty", r), ib.empty, 1);
        end
        for (int i = 0; i < 5; i++) step_b(1'b1, 1'b0, 8'(8'hC0 + i));
        chk("b_full", ib.full, 1);
        chk("b_count", ib.count, 5);
        chk("b_af", ib.almost_full, 1);
        step_b(1'b1, 1'b0, 8'hFF);
        chk("b_ovf", ib.overflow, 1);
        chk("b_head", ib.r_data, 8'hC0);
        step_c(1'b1, 1'b0, 8'h10);
        step_c(1'b1, 1'b0, 8'h20);
        step_c(1'b1, 1'b0, 8'h30);
        chk("c_wr_rvalid", ic.r_valid, 0);
        chk("c_wr_rdata", ic.r_data, 0);
        step_c(1'b0, 1'b1, 8'h00);
        chk("c_rd1_rvalid", ic.r_valid, 1);
        chk("c_rd1_rdata", ic.r_data, 8'h10);
        chk("c_rd1_count", ic.count, 2);
        step_c(1'b0, 1'b0, 8'h00);
        chk("c_idle_rvalid", ic.r_valid, 0);
        chk("c_idle_rdata", ic.r_data, 8'h10);
        step_c(1'b0, 1'b1, 8'h00);
        chk("c_rd2_rvalid", ic.r_valid, 1);
        chk("c_rd2_rdata", ic.r_data, 8'h20);
        step_c(1'b0, 1'b1, 8'h00);
        chk("c_rd3_rvalid", ic.r_valid, 1);
        chk("c_rd3_rdata", ic.r_data, 8'h30);
        chk("c_rd3_empty", ic.empty, 1);
        step_c(1'b0, 1'b1, 8'h00);
        chk("c_rd4_rvalid", ic.r_valid, 0);
        chk("c_rd4_un", ic.underflow, 1);
        chk("c_rd4_rdata", ic.r_data, 8'h30);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
